mac_stream_acc: RTL and testbench

// - Parametrised, pipelined multiply-accumulate engine; next generation of the MAC top module.
// - On a go pulse, accepts N_SAMPLES operand pairs over a valid/ready handshake and sums their products.
// - Presents the registered sum on out with a one-cycle done pulse.
// - Sits between an operand source (counter/ROM/bench) and downstream result logic; tolerates bubbles on in_valid.

---
 rtl/mac_stream_acc.sv | 144 ++++++++++++++
 tb/tb_mac_stream_acc.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_stream_acc.sv
// mac_stream_acc: pipelined multiply-accumulate over N_SAMPLES operand
// pairs taken in on a valid/ready handshake, started by a go pulse.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   go        start request, sampled only while idle
//   A, B      unsigned operands, sampled on accept
//   in_valid  operands present this cycle
//   in_ready  engine accepting operands (registered, high only in RUN)
//   busy      run in progress (RUN or FLUSH)
//   out       result of the last completed run
//   done      one-cycle pulse coincident with an out update
//   ovf       accumulator carried out of ACC_W during the last run
//
// Build option MAC_SAT_EN: when defined the accumulator clamps to all
// ones on carry-out; otherwise it wraps modulo 2**ACC_W.

module mac_stream_acc #(
    parameter int DATA_W    = 4,
    parameter int ACC_W     = 12,
    parameter int N_SAMPLES = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              busy,
    output logic [ACC_W-1:0]  out,
    output logic              done,
    output logic              ovf
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int CNT_W  = $clog2(N_SAMPLES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SAMPLES - 1);

    generate
        if (ACC_W < 2 * DATA_W) begin : g_bad_acc_w
            $error("mac_stream_acc: ACC_W must be >= 2*DATA_W");
        end
        if (N_SAMPLES < 1) begin : g_bad_n
            $error("mac_stream_acc: N_SAMPLES must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CNT_W-1:0]  count;
    logic [PROD_W-1:0] prod;
    logic              prod_v;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_sum;
    logic [ACC_W-1:0]  acc_upd;
    logic              carry;
    logic              ovf_run;
    logic              accept;
    logic              last_accept;
    logic              start;

    assign accept      = in_valid & in_ready;
    assign last_accept = accept && (count == LAST_CNT);
    assign start       = (state == S_IDLE) && go;
    assign busy        = (state != S_IDLE);

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (go) state_nxt = S_RUN;
            S_RUN:   if (last_accept) state_nxt = S_FLUSH;
            S_FLUSH: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Stage-2 adder with an explicit carry bit for overflow detection.
    always_comb begin
        {carry, acc_sum} = {1'b0, acc} + (ACC_W + 1)'(prod);
`ifdef MAC_SAT_EN
        // Once clamped, any further non-zero product carries again,
        // so the accumulator stays pinned at all ones.
        acc_upd = carry ? {ACC_W{1'b1}} : acc_sum;
`else
        acc_upd = acc_sum;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            count    <= '0;
            prod     <= '0;
            prod_v   <= 1'b0;
            acc      <= '0;
            ovf_run  <= 1'b0;
            in_ready <= 1'b0;
            out      <= '0;
            done     <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            state  <= state_nxt;
            done   <= 1'b0;
            prod_v <= accept;

            if (accept) begin
                prod  <= PROD_W'(A) * PROD_W'(B);
                count <= count + 1'b1;
            end

            if (start) begin
                acc      <= '0;
                count    <= '0;
                ovf_run  <= 1'b0;
                in_ready <= 1'b1;
            end else if (prod_v) begin
                acc     <= acc_upd;
                ovf_run <= ovf_run | carry;
            end

            if (last_accept) begin
                in_ready <= 1'b0;
            end

            // The last product lands in FLUSH; publish the final sum
            // on the same edge it is formed.
            if (state == S_FLUSH) begin
                out  <= prod_v ? acc_upd : acc;
                ovf  <= ovf_run | (prod_v & carry);
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mac_stream_acc.sv
// tb_mac_stream_acc: table-driven, hand-written and randomized checks of
// mac_stream_acc against a sum-of-products reference model.

module tb_mac_stream_acc;

`ifdef MAC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        go = 1'b0;
    logic [4:0]  A = '0;
    logic [4:0]  B = '0;
    logic        in_valid = 1'b0;

    logic        in_ready;
    logic        busy;
    logic [11:0] out;
    logic        done;
    logic        ovf;

    logic        in_ready8;
    logic        busy8;
    logic [7:0]  out8;
    logic        done8;
    logic        ovf8;

    int n_err = 0;
    int n_checks = 0;

    always #5 clk = ~clk;

    mac_stream_acc #(.DATA_W(5), .ACC_W(12), .N_SAMPLES(10)) dut (
        .clk(clk), .rst(rst), .go(go), .A(A), .B(B),
        .in_valid(in_valid), .in_ready(in_ready), .busy(busy),
        .out(out), .done(done), .ovf(ovf)
    );

    mac_stream_acc #(.DATA_W(4), .ACC_W(8), .N_SAMPLES(10)) dut8 (
        .clk(clk), .rst(rst), .go(go), .A(A[3:0]), .B(B[3:0]),
        .in_valid(in_valid), .in_ready(in_ready8), .busy(busy8),
        .out(out8), .done(done8), .ovf(ovf8)
    );

    typedef struct {
        logic [49:0] av;
        logic [49:0] bv;
        int          bub;
        int          e12;
        bit          o12;
        int          e8;
        bit          o8;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic longint sum_prod(input logic [49:0] av,
                                        input logic [49:0] bv,
                                        input int w);
        longint s = 0;
        for (int i = 0; i < 10; i++) begin
            logic [4:0] a = av[5*i +: 5];
            logic [4:0] b = bv[5*i +: 5];
            if (w == 4) begin
                a = a & 5'h0F;
                b = b & 5'h0F;
            end
            s += longint'(a) * longint'(b);
        end
        return s;
    endfunction

    function automatic longint model_out(input longint s, input int aw);
        longint lim = longint'(1) << aw;
        if (s >= lim) return SAT ? lim - 1 : s % lim;
        return s;
    endfunction

    // Starts and ends on a falling edge.
    task automatic start_run(input bit hold);
        go = 1'b1;
        @(negedge clk);
        if (!hold) go = 1'b0;
        chk("start_ready", in_ready, 1);
        chk("start_busy", busy, 1);
    endtask

    task automatic feed(input logic [49:0] av, input logic [49:0] bv,
                        input int bub, input int first, input int last);
        int idx = first;
        int cyc = 0;
        bit acc_now;
        while (idx < last && cyc < 200) begin
            bit bubble;
            bubble = (bub == 1) ? (cyc % 2 == 1) :
                     (bub == 2) ? ($urandom_range(0, 99) < 35) : 1'b0;
            if (bubble) begin
                in_valid = 1'b0;
                A = 5'($urandom);
                B = 5'($urandom);
            end else begin
                in_valid = 1'b1;
                A = av[5*idx +: 5];
                B = bv[5*idx +: 5];
            end
            chk("ready_in_run", in_ready, 1);
            acc_now = in_valid && in_ready;
            @(posedge clk);
            if (acc_now) idx++;
            cyc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("feed_accepts", 64'(idx), 64'(last));
    endtask

    task automatic end_check(input string nm, input int e12, input bit o12,
                             input int e8, input bit o8);
        chk({nm, "_ready_off"}, in_ready, 0);
        chk({nm, "_flush_busy"}, busy, 1);
        chk({nm, "_early_done"}, done, 0);
        @(negedge clk);
        chk({nm, "_done"}, done, 1);
        chk({nm, "_out"}, out, 64'(e12));
        chk({nm, "_ovf"}, ovf, o12);
        chk({nm, "_done8"}, done8, 1);
        chk({nm, "_out8"}, out8, 64'(e8));
        chk({nm, "_ovf8"}, ovf8, o8);
        @(negedge clk);
        chk({nm, "_done_off"}, done, 0);
        chk({nm, "_out_hold"}, out, 64'(e12));
    endtask

    initial begin
        logic [49:0] ba, bb, z, f15, ones, f31, b15;
        for (int i = 0; i < 10; i++) begin
            ba[5*i +: 5]   = 5'(i);
            bb[5*i +: 5]   = 5'(2 * i + 1);
            z[5*i +: 5]    = 5'd0;
            f15[5*i +: 5]  = 5'd15;
            ones[5*i +: 5] = 5'd1;
            f31[5*i +: 5]  = 5'd31;
            b15[5*i +: 5]  = 5'd15;
        end
        vecs[0] = '{ba, bb, 0, 615, 0, SAT ? 255 : 87, 1};
        vecs[1] = '{ba, bb, 1, 615, 0, SAT ? 255 : 87, 1};
        vecs[2] = '{z, z, 0, 0, 0, 0, 0};
        vecs[3] = '{f15, f15, 0, 2250, 0, SAT ? 255 : 202, 1};
        vecs[4] = '{ones, ones, 1, 10, 0, 10, 0};
        vecs[5] = '{f31, f31, 0, SAT ? 4095 : 1418, 1, SAT ? 255 : 202, 1};
        vecs[6] = '{ba, b15, 2, 675, 0, SAT ? 255 : 163, 1};

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_out", out, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_busy", busy, 0);

        for (int v = 0; v < 7; v++) begin
            start_run(1'b0);
            feed(vecs[v].av, vecs[v].bv, vecs[v].bub, 0, 10);
            end_check($sformatf("vec%0d", v), vecs[v].e12, vecs[v].o12,
                      vecs[v].e8, vecs[v].o8);
        end

        // in_valid while idle is ignored
        start_run(1'b0);
        feed(ba, bb, 0, 0, 10);
        end_check("pre_idle", 615, 0, SAT ? 255 : 87, 1);
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1;
            A = 5'($urandom);
            B = 5'($urandom);
            @(negedge clk);
            chk("idle_ready", in_ready, 0);
            chk("idle_done", done, 0);
            chk("idle_out", out, 615);
        end
        in_valid = 1'b0;

        // reset mid-run
        start_run(1'b0);
        feed(ba, bb, 0, 0, 5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_out", out, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_ovf8", ovf8, 0);
        chk("mid_rst_ready", in_ready, 0);
        chk("mid_rst_busy", busy, 0);
        @(negedge clk);
        chk("mid_rst_no_done", done, 0);
        start_run(1'b0);
        feed(ba, bb, 0, 0, 10);
        end_check("after_rst", 615, 0, SAT ? 255 : 87, 1);

        // go pulsed during RUN is ignored
        start_run(1'b0);
        feed(ba, bb, 0, 0, 5);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        feed(ba, bb, 0, 5, 10);
        end_check("go_in_run", 615, 0, SAT ? 255 : 87, 1);
        begin
            int extra = 0;
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                if (done || busy) extra++;
            end
            chk("go_in_run_single", 64'(extra), 0);
        end

        // go held across done: second run starts by itself
        start_run(1'b1);
        feed(ba, bb, 0, 0, 10);
        end_check("held_1", 615, 0, SAT ? 255 : 87, 1);
        go = 1'b0;
        chk("held_restart_busy", busy, 1);
        feed(ones, ones, 0, 0, 10);
        chk("held_out_kept", out, 615);
        end_check("held_2", 10, 0, 10, 0);

        // randomized runs against the reference model
        for (int r = 0; r < 12; r++) begin
            logic [49:0] ra, rb;
            longint s12, s8;
            ra = 50'({$urandom, $urandom});
            rb = 50'({$urandom, $urandom});
            s12 = sum_prod(ra, rb, 5);
            s8  = sum_prod(ra, rb, 4);
            start_run(1'b0);
            feed(ra, rb, 2, 0, 10);
            end_check($sformatf("rand%0d", r),
                      int'(model_out(s12, 12)), s12 >= 4096,
                      int'(model_out(s8, 8)), s8 >= 256);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
